// File: rtl/tst_dout_mon_mc.sv
// rtl/tst_dout_mon_mc.sv - multi-lane output monitor against a prefetched golden ROM stream
//
// Ports:
//   clk, rst_i            clock, asynchronous active-high reset
//   dout_rst_i            synchronous restart (counters, FIFO, address; in-flight reads are dropped)
//   vld_i, dat_i          DUT beat, NCH lanes of DATABW bits, lane k at [k*DATABW +: DATABW]
//   gold_re_o/addr_o      golden ROM read request
//   gold_vld_i/dat_i      golden ROM read return, ROMLAT cycles after the request
//   vld_o, mis_o          per-beat compare result pulse
//   smp/err/idl/lat_cnt_o saturating statistics counters
//   err_lane_o            sticky per-lane mismatch map
//   first_err_o           sample index of first mismatching beat, all-ones when none
//   unf_o                 sticky: beat arrived with no golden word available
//   done_o                NSMP beats compared
module tst_dout_mon_mc #(
    parameter int NCH        = 4,
    parameter int DATABW     = 64,
    parameter int ADDR_BW    = 15,
    parameter int ROMLEN     = 32768,
    parameter int ROMLAT     = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int NSMP       = 4096,
    parameter int TOL        = 0,
    parameter int CNT_BW     = 16
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    dout_rst_i,
    input  logic                    vld_i,
    input  logic [NCH*DATABW-1:0]   dat_i,
    output logic                    gold_re_o,
    output logic [ADDR_BW-1:0]      gold_addr_o,
    input  logic                    gold_vld_i,
    input  logic [NCH*DATABW-1:0]   gold_dat_i,
    output logic                    vld_o,
    output logic                    mis_o,
    output logic [CNT_BW-1:0]       smp_cnt_o,
    output logic [CNT_BW-1:0]       err_cnt_o,
    output logic [CNT_BW-1:0]       idl_cnt_o,
    output logic [CNT_BW-1:0]       lat_cnt_o,
    output logic [NCH-1:0]          err_lane_o,
    output logic [CNT_BW-1:0]       first_err_o,
    output logic                    unf_o,
    output logic                    done_o
);

    localparam int HB = DATABW / 2;
    localparam int WW = NCH * DATABW;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Occupancy, in-flight and drop counts share one width with headroom for their sum.
    localparam int OW = $clog2(FIFO_DEPTH + 1) + 1;

    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_BW-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_BW-1:0]  NSMP_C    = CNT_BW'(NSMP);
    localparam logic [ADDR_BW-1:0] ADDR_LAST = ADDR_BW'(ROMLEN - 1);
    localparam logic [HB:0]        TOL_C     = (HB + 1)'(TOL);
    localparam logic [PW-1:0]      PTR_LAST  = PW'(FIFO_DEPTH - 1);
    localparam logic [OW-1:0]      DEPTH_C   = OW'(FIFO_DEPTH);

    generate
        if (longint'(NSMP) >= (64'd1 << CNT_BW)) begin : g_bad_nsmp
            $error("NSMP must be below 2**CNT_BW so the sample counter can reach it");
        end
        if (FIFO_DEPTH < ROMLAT + 2) begin : g_bad_depth
            $error("FIFO_DEPTH must be at least ROMLAT+2 to cover the ROM latency");
        end
    endgenerate

    logic [1:0]    state;
    logic [WW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [OW-1:0] fifo_cnt;
    logic [OW-1:0] infl_cnt;
    logic [OW-1:0] drop_cnt;

    logic              fifo_empty;
    logic              active;
    logic              vld_drop;
    logic              fifo_wr;
    logic              beat;
    logic              fifo_rd;
    logic [WW-1:0]     head;
    logic [NCH-1:0]    lane_mis;
    logic              beat_mis;
    logic [OW-1:0]     infl_nxt;
    logic [OW-1:0]     drop_nxt;
    logic [CNT_BW-1:0] smp_inc;

    // Signed half-lane compare; one extra bit keeps the difference from overflowing.
    function automatic logic half_ok(input logic [HB-1:0] a, input logic [HB-1:0] b);
        logic signed [HB:0] d;
        logic [HB:0]        m;
        d = $signed({a[HB-1], a}) - $signed({b[HB-1], b});
        m = d[HB] ? -d : d;
        return m <= TOL_C;
    endfunction

    assign fifo_empty = (fifo_cnt == '0);
    assign active     = (state != S_DONE);
    // Reads are held off during a restart cycle so the drop count only covers
    // requests that were really issued before it.
    assign gold_re_o  = active && !dout_rst_i && ((fifo_cnt + infl_cnt) < DEPTH_C);
    assign vld_drop   = gold_vld_i && (drop_cnt != '0);
    assign fifo_wr    = gold_vld_i && (drop_cnt == '0);
    assign beat       = vld_i && active;
    assign fifo_rd    = beat && !fifo_empty;
    assign head       = fifo_mem[rd_ptr];
    assign infl_nxt   = infl_cnt + OW'(gold_re_o) - OW'(fifo_wr);
    assign drop_nxt   = drop_cnt - OW'(vld_drop);
    assign smp_inc    = (smp_cnt_o == CNT_MAX) ? smp_cnt_o : smp_cnt_o + 1'b1;
    assign done_o     = (state == S_DONE);

    always_comb begin
        lane_mis = '0;
        for (int k = 0; k < NCH; k++) begin
            lane_mis[k] = !(half_ok(dat_i[k*DATABW +: HB], head[k*DATABW +: HB]) &&
                            half_ok(dat_i[k*DATABW+HB +: HB], head[k*DATABW+HB +: HB]));
        end
        // No golden word available: every lane is treated as wrong.
        if (fifo_empty) begin
            lane_mis = '1;
        end
    end

    assign beat_mis = |lane_mis;

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr] <= gold_dat_i;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (dout_rst_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (fifo_rd) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            fifo_cnt <= fifo_cnt + OW'(fifo_wr) - OW'(fifo_rd);
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            gold_addr_o <= '0;
            infl_cnt    <= '0;
            drop_cnt    <= '0;
        end else if (dout_rst_i) begin
            // Everything still in the ROM pipe belongs to the old run and must be discarded.
            gold_addr_o <= '0;
            infl_cnt    <= '0;
            drop_cnt    <= drop_nxt + infl_nxt;
        end else begin
            if (gold_re_o) begin
                gold_addr_o <= (gold_addr_o == ADDR_LAST) ? '0 : gold_addr_o + 1'b1;
            end
            infl_cnt <= infl_nxt;
            drop_cnt <= drop_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_WAIT;
            vld_o       <= 1'b0;
            mis_o       <= 1'b0;
            smp_cnt_o   <= '0;
            err_cnt_o   <= '0;
            idl_cnt_o   <= '0;
            lat_cnt_o   <= '0;
            err_lane_o  <= '0;
            first_err_o <= '1;
            unf_o       <= 1'b0;
        end else if (dout_rst_i) begin
            state       <= S_WAIT;
            vld_o       <= 1'b0;
            mis_o       <= 1'b0;
            smp_cnt_o   <= '0;
            err_cnt_o   <= '0;
            idl_cnt_o   <= '0;
            lat_cnt_o   <= '0;
            err_lane_o  <= '0;
            first_err_o <= '1;
            unf_o       <= 1'b0;
        end else begin
            vld_o <= 1'b0;
            mis_o <= 1'b0;
            if (state == S_WAIT && !vld_i && lat_cnt_o != CNT_MAX) begin
                lat_cnt_o <= lat_cnt_o + 1'b1;
            end
            if (state == S_RUN && !vld_i && idl_cnt_o != CNT_MAX) begin
                idl_cnt_o <= idl_cnt_o + 1'b1;
            end
            if (beat) begin
                vld_o     <= 1'b1;
                mis_o     <= beat_mis;
                smp_cnt_o <= smp_inc;
                if (fifo_empty) begin
                    unf_o <= 1'b1;
                end
                if (beat_mis) begin
                    if (err_cnt_o != CNT_MAX) begin
                        err_cnt_o <= err_cnt_o + 1'b1;
                    end
                    err_lane_o <= err_lane_o | lane_mis;
                    if (first_err_o == CNT_MAX) begin
                        first_err_o <= smp_cnt_o;
                    end
                end
                state <= (smp_inc == NSMP_C) ? S_DONE : S_RUN;
            end
        end
    end

    // The prefetch throttle bounds occupancy plus in-flight by FIFO_DEPTH,
    // so a kept ROM return can never meet a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst_i)
        !(fifo_wr && !dout_rst_i && fifo_cnt == DEPTH_C));

endmodule

// File: tb/tb_tst_dout_mon_mc.sv
// tb/tb_tst_dout_mon_mc.sv - self-checking bench for tst_dout_mon_mc
module tb_tst_dout_mon_mc;

    localparam int NCH        = 4;
    localparam int DATABW     = 16;
    localparam int ADDR_BW    = 4;
    localparam int ROMLEN     = 8;
    localparam int ROMLAT     = 5;
    localparam int FIFO_DEPTH = 8;
    localparam int NSMP       = 20;
    localparam int TOL        = 2;
    localparam int CNT_BW     = 16;
    localparam int WW         = NCH * DATABW;
    localparam int HB         = DATABW / 2;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              dout_rst_i = 1'b0;
    logic              vld_i = 1'b0;
    logic [WW-1:0]     dat_i = '0;
    logic              gold_re_o;
    logic [ADDR_BW-1:0] gold_addr_o;
    logic              gold_vld_i;
    logic [WW-1:0]     gold_dat_i;
    logic              vld_o;
    logic              mis_o;
    logic [CNT_BW-1:0] smp_cnt_o;
    logic [CNT_BW-1:0] err_cnt_o;
    logic [CNT_BW-1:0] idl_cnt_o;
    logic [CNT_BW-1:0] lat_cnt_o;
    logic [NCH-1:0]    err_lane_o;
    logic [CNT_BW-1:0] first_err_o;
    logic              unf_o;
    logic              done_o;

    always #5 clk = ~clk;

    tst_dout_mon_mc #(
        .NCH(NCH), .DATABW(DATABW), .ADDR_BW(ADDR_BW), .ROMLEN(ROMLEN), .ROMLAT(ROMLAT),
        .FIFO_DEPTH(FIFO_DEPTH), .NSMP(NSMP), .TOL(TOL), .CNT_BW(CNT_BW)
    ) dut (
        .clk(clk), .rst_i(rst_i), .dout_rst_i(dout_rst_i), .vld_i(vld_i), .dat_i(dat_i),
        .gold_re_o(gold_re_o), .gold_addr_o(gold_addr_o), .gold_vld_i(gold_vld_i),
        .gold_dat_i(gold_dat_i), .vld_o(vld_o), .mis_o(mis_o), .smp_cnt_o(smp_cnt_o),
        .err_cnt_o(err_cnt_o), .idl_cnt_o(idl_cnt_o), .lat_cnt_o(lat_cnt_o),
        .err_lane_o(err_lane_o), .first_err_o(first_err_o), .unf_o(unf_o), .done_o(done_o)
    );

    function automatic logic [WW-1:0] gold_of(input int a);
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < NCH; k++) begin
            w[k*DATABW +: HB]    = HB'((a * 5 + k * 11) % 64);
            w[k*DATABW+HB +: HB] = HB'((a * 9 + k * 3 + 1) % 128);
        end
        return w;
    endfunction

    function automatic logic [WW-1:0] perturb(input logic [WW-1:0] w, input logic [NCH-1:0] lanes,
                                              input int delta);
        logic [WW-1:0] r;
        r = w;
        for (int k = 0; k < NCH; k++) begin
            if (lanes[k]) r[k*DATABW +: HB] = r[k*DATABW +: HB] + HB'(delta);
        end
        return r;
    endfunction

    // Golden ROM model: fixed-latency pipe, not flushed by dout_rst_i.
    logic [ROMLAT-1:0] vp;
    logic [WW-1:0]     dp [ROMLAT];
    int                out_cnt;
    int                max_out;
    logic [ADDR_BW-1:0] last_addr;
    logic              wrap_seen;

    assign gold_vld_i = vp[ROMLAT-1];
    assign gold_dat_i = dp[ROMLAT-1];

    always @(posedge clk) begin
        if (rst_i) begin
            vp        <= '0;
            out_cnt   <= 0;
            max_out   <= 0;
            last_addr <= '0;
            wrap_seen <= 1'b0;
        end else begin
            vp    <= {vp[ROMLAT-2:0], gold_re_o};
            dp[0] <= gold_of(int'(gold_addr_o));
            for (int i = 1; i < ROMLAT; i++) dp[i] <= dp[i-1];
            out_cnt <= out_cnt + int'(gold_re_o) - int'(vld_i);
            if (out_cnt + int'(gold_re_o) - int'(vld_i) > max_out)
                max_out <= out_cnt + int'(gold_re_o) - int'(vld_i);
            if (gold_re_o) begin
                if (last_addr == ADDR_BW'(ROMLEN - 1) && gold_addr_o == '0) wrap_seen <= 1'b1;
                last_addr <= gold_addr_o;
            end
        end
    end

    typedef struct {
        int             gap;
        logic [NCH-1:0] lanes;
        int             delta;
        logic           exp_mis;
    } vec_t;

    vec_t tab [NSMP];
    logic exp_q [$];
    int   total = 0;
    int   bad = 0;
    int   mis_pulses = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_out();
        logic e;
        if (vld_o) begin
            if (exp_q.size() == 0) begin
                chk("vld_o_unexpected", vld_o, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("mis_o", mis_o, e);
                if (mis_o) mis_pulses++;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic drive_beat(input logic [WW-1:0] d, input logic e_mis);
        vld_i = 1'b1;
        dat_i = d;
        exp_q.push_back(e_mis);
        cycle();
        vld_i = 1'b0;
        dat_i = '0;
    endtask

    task automatic restart();
        dout_rst_i = 1'b1;
        cycle();
        dout_rst_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NSMP; i++)
            tab[i] = '{gap: (i == 0) ? 10 : 2, lanes: '0, delta: 0, exp_mis: 1'b0};
        tab[5]  = '{gap: 2, lanes: 4'b0100, delta: 64, exp_mis: 1'b1};
        tab[9]  = '{gap: 2, lanes: 4'b0001, delta: 64, exp_mis: 1'b1};
        tab[12] = '{gap: 2, lanes: 4'b0010, delta: 2,  exp_mis: 1'b0};
        tab[15] = '{gap: 2, lanes: 4'b0010, delta: -3, exp_mis: 1'b1};
        tab[17] = '{gap: 2, lanes: 4'b1000, delta: -2, exp_mis: 1'b0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_vld_o", vld_o, 0);
        chk("rst_smp", smp_cnt_o, 0);
        chk("rst_err", err_cnt_o, 0);
        chk("rst_lat", lat_cnt_o, 0);
        chk("rst_lane", err_lane_o, 0);
        chk("rst_first_err", first_err_o, 16'hffff);
        chk("rst_unf", unf_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_addr", gold_addr_o, 0);
        rst_i = 1'b0;

        // Clean back-to-back run after 20 idle WAIT cycles
        idle(20);
        chk("lat_20", lat_cnt_o, 20);
        for (int i = 0; i < NSMP; i++) begin
            drive_beat(gold_of(i % ROMLEN), 1'b0);
            chk("done_timing", done_o, (i == NSMP - 1));
        end
        chk("a_smp", smp_cnt_o, NSMP);
        chk("a_err", err_cnt_o, 0);
        chk("a_idl", idl_cnt_o, 0);
        chk("a_lat", lat_cnt_o, 20);
        chk("a_first_err", first_err_o, 16'hffff);
        chk("a_wrap", wrap_seen, 1);
        chk("a_outstanding_le_depth", (max_out <= FIFO_DEPTH), 1);
        // Beats after DONE are ignored
        vld_i = 1'b1;
        dat_i = '1;
        idle(3);
        vld_i = 1'b0;
        chk("a_frozen_smp", smp_cnt_o, NSMP);
        chk("a_frozen_err", err_cnt_o, 0);
        idle(8);

        // Table run: gapped beats, corrupted lanes, tolerance edges
        restart();
        chk("b_restart_addr", gold_addr_o, 0);
        chk("b_restart_done", done_o, 0);
        chk("b_restart_smp", smp_cnt_o, 0);
        mis_pulses = 0;
        for (int i = 0; i < NSMP; i++) begin
            idle(tab[i].gap);
            if (i == 0) chk("b_lat", lat_cnt_o, 10);
            drive_beat(perturb(gold_of(i % ROMLEN), tab[i].lanes, tab[i].delta), tab[i].exp_mis);
        end
        chk("b_err", err_cnt_o, 3);
        chk("b_lane", err_lane_o, 4'b0111);
        chk("b_first_err", first_err_o, 5);
        chk("b_mis_pulses", mis_pulses, 3);
        chk("b_idl", idl_cnt_o, 38);
        chk("b_smp", smp_cnt_o, NSMP);
        chk("b_done", done_o, 1);
        chk("b_unf", unf_o, 0);
        idle(8);

        // Underflow: beat straight after restart, FIFO still empty
        restart();
        drive_beat({WW{1'b1}}, 1'b1);
        chk("c_unf", unf_o, 1);
        idle(12);
        for (int i = 0; i < 6; i++) drive_beat(gold_of(i % ROMLEN), 1'b0);
        chk("c_err", err_cnt_o, 1);
        chk("c_lane", err_lane_o, 4'b1111);
        chk("c_first_err", first_err_o, 0);
        chk("c_smp", smp_cnt_o, 7);
        chk("c_unf_sticky", unf_o, 1);

        // Restart with reads in flight, then a second restart inside the drop window
        restart();
        cycle();
        restart();
        chk("d_restart_addr", gold_addr_o, 0);
        chk("d_restart_unf", unf_o, 0);
        idle(15);
        for (int i = 0; i < NSMP; i++) drive_beat(gold_of(i % ROMLEN), 1'b0);
        chk("d_err", err_cnt_o, 0);
        chk("d_lane", err_lane_o, 0);
        chk("d_smp", smp_cnt_o, NSMP);
        chk("d_done", done_o, 1);
        chk("d_unf", unf_o, 0);
        chk("d_first_err", first_err_o, 16'hffff);
        idle(4);
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
